// File: rtl/signal_composer_n.sv
// DAC-channel composer: adder tree over N_WAVES signed lanes, plus a gated seq+offset term,
// ramped output gain and saturation to DATA_W. Fixed latency of clog2(N_WAVES)+4 clocks.
module signal_composer_n #(
  parameter int N_WAVES = 4,
  parameter int DATA_W  = 16,
  parameter int GAIN_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_WAVES*DATA_W-1:0]   wave_in,
  input  logic [N_WAVES-1:0]          valid_in,
  input  logic [DATA_W-1:0]           offset,
  input  logic [DATA_W-1:0]           seq,
  input  logic                        dyn_offset_disable,
  input  logic                        disable_dac,
  input  logic [GAIN_W-1:0]           ramp_step,
  output logic [DATA_W-1:0]           signal_out,
  output logic                        signal_valid,
  output logic                        sat,
  output logic                        dac_active,
  output logic                        ramp_busy
);
  localparam int T  = (N_WAVES > 1) ? $clog2(N_WAVES) : 0;
  localparam int L  = T + 4;
  localparam int TW = DATA_W + T;
  localparam int SW = DATA_W + T + 2;
  localparam int PW = SW + GAIN_W + 1;
  localparam logic [GAIN_W:0]        FULL = {2'b01, {(GAIN_W-1){1'b0}}};
  localparam logic signed [PW-1:0]   MAXV = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0]   MINV = ~MAXV;

  typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_e;

  state_e          state_q, state_d;
  logic [GAIN_W:0] gain_q, gain_d, up_sum, up_g, dn_g;
  logic            step_zero;

  // Gain FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OFF;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  // Next state: every non-OFF state moves one step toward the target set by disable_dac,
  // so reversing direction mid-ramp continues from the current gain.
  always_comb begin
    step_zero = (ramp_step == '0);
    up_sum    = gain_q + {1'b0, ramp_step};
    up_g      = (step_zero || up_sum >= FULL) ? FULL : up_sum;
    dn_g      = (step_zero || {1'b0, ramp_step} >= gain_q) ? '0 : gain_q - {1'b0, ramp_step};
    state_d   = state_q;
    gain_d    = gain_q;
    case (state_q)
      S_OFF: begin
        gain_d = '0;
        if (!disable_dac) state_d = S_UP;
      end
      default: begin
        if (disable_dac) begin
          gain_d  = dn_g;
          state_d = (dn_g == '0) ? S_OFF : S_DOWN;
        end else begin
          gain_d  = up_g;
          state_d = (up_g == FULL) ? S_ON : S_UP;
        end
      end
    endcase
  end

  always_comb begin
    dac_active = (state_q == S_ON);
    ramp_busy  = (state_q == S_UP) || (state_q == S_DOWN);
  end

  // Datapath
  logic signed [TW-1:0]     lvl_d [0:T][0:N_WAVES-1];
  logic signed [TW-1:0]     lvl_q [0:T][0:N_WAVES-1];
  logic signed [DATA_W:0]   off_in;
  logic signed [DATA_W:0]   off_q [0:T];
  logic signed [SW-1:0]     sum_q;
  logic signed [PW-1:0]     prod, m_q;
  logic [DATA_W-1:0]        out_d;
  logic                     sat_d;
  logic [L-1:0]             vld_q;

  assign off_in = dyn_offset_disable ? '0
                : $signed({offset[DATA_W-1], offset}) + $signed({seq[DATA_W-1], seq});

  for (genvar j = 0; j < N_WAVES; j++) begin : g_lane
    assign lvl_d[0][j] = TW'($signed(wave_in[j*DATA_W +: DATA_W]));
  end

  // Level l pairs nodes of level l-1; an unpaired last node passes through registered.
  for (genvar l = 1; l <= T; l++) begin : g_lvl
    localparam int NP = (N_WAVES + (1 << (l-1)) - 1) >> (l-1);
    for (genvar j = 0; j < N_WAVES; j++) begin : g_node
      if (2*j+1 < NP) begin : g_add
        assign lvl_d[l][j] = lvl_q[l-1][2*j] + lvl_q[l-1][2*j+1];
      end else if (2*j < NP) begin : g_pass
        assign lvl_d[l][j] = lvl_q[l-1][2*j];
      end else begin : g_nil
        assign lvl_d[l][j] = '0;
      end
    end
  end

  assign prod = PW'(sum_q) * $signed(PW'(gain_q));

  always_comb begin
    out_d = m_q[DATA_W-1:0];
    sat_d = 1'b0;
    if (m_q > MAXV) begin
      out_d = MAXV[DATA_W-1:0];
      sat_d = 1'b1;
    end else if (m_q < MINV) begin
      out_d = MINV[DATA_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l <= T; l++) begin
        off_q[l] <= '0;
        for (int j = 0; j < N_WAVES; j++) lvl_q[l][j] <= '0;
      end
      sum_q      <= '0;
      m_q        <= '0;
      signal_out <= '0;
      sat        <= 1'b0;
      vld_q      <= '0;
    end else begin
      lvl_q    <= lvl_d;
      off_q[0] <= off_in;
      for (int l = 1; l <= T; l++) off_q[l] <= off_q[l-1];
      sum_q      <= SW'(lvl_q[T][0]) + SW'(off_q[T]);
      m_q        <= prod >>> (GAIN_W-1);
      signal_out <= out_d;
      sat        <= sat_d;
      vld_q      <= {vld_q[L-2:0], &valid_in};
    end
  end

  assign signal_valid = vld_q[L-1];

endmodule

// File: tb/tb_signal_composer_n.sv
// Bench for signal_composer_n: directed gain/latency/saturation steps on a 4-lane build,
// then randomized lanes on 1-, 4- and 5-lane builds checked against an arithmetic model.
module tb_signal_composer_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, dyn, dis;
  logic [15:0] offset, seq, rstep;
  logic [63:0] w4;  logic [3:0] v4;
  logic [15:0] w1;  logic       v1;
  logic [79:0] w5;  logic [4:0] v5;
  logic [15:0] o4, o1, o5;
  logic sv4, sv1, sv5, sat4, sat1, sat5, act4, act1, act5, busy4, busy1, busy5;

  signal_composer_n #(.N_WAVES(4), .DATA_W(16), .GAIN_W(16)) dut4 (
    .clk(clk), .reset(reset), .wave_in(w4), .valid_in(v4), .offset(offset), .seq(seq),
    .dyn_offset_disable(dyn), .disable_dac(dis), .ramp_step(rstep), .signal_out(o4),
    .signal_valid(sv4), .sat(sat4), .dac_active(act4), .ramp_busy(busy4));
  signal_composer_n #(.N_WAVES(1), .DATA_W(16), .GAIN_W(16)) dut1 (
    .clk(clk), .reset(reset), .wave_in(w1), .valid_in(v1), .offset(offset), .seq(seq),
    .dyn_offset_disable(dyn), .disable_dac(dis), .ramp_step(rstep), .signal_out(o1),
    .signal_valid(sv1), .sat(sat1), .dac_active(act1), .ramp_busy(busy1));
  signal_composer_n #(.N_WAVES(5), .DATA_W(16), .GAIN_W(16)) dut5 (
    .clk(clk), .reset(reset), .wave_in(w5), .valid_in(v5), .offset(offset), .seq(seq),
    .dyn_offset_disable(dyn), .disable_dac(dis), .ramp_step(rstep), .signal_out(o5),
    .signal_valid(sv5), .sat(sat5), .dac_active(act5), .ramp_busy(busy5));

  int nchk = 0, npass = 0, nfail = 0, cyc = 0;

  longint eo4 [0:4095], eo1 [0:4095], eo5 [0:4095];
  logic   es4 [0:4095], es1 [0:4095], es5 [0:4095];
  logic   ev4 [0:4095], ev1 [0:4095], ev5 [0:4095];

  task automatic chk(input string tag, input longint obs, input longint exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set4(input int a, input int b, input int c, input int d);
    w4 = {16'(d), 16'(c), 16'(b), 16'(a)};
    v4 = 4'hf;
  endtask

  // Reference: floor(sum*gain/FULL), then clip to the signed 16-bit range.
  task automatic model(input longint s, input longint g, output longint o, output logic sf);
    longint p;
    p = (s * g) >>> 15;
    sf = 1'b1;
    if (p > 32767) o = 32767;
    else if (p < -32768) o = -32768;
    else begin
      o = p;
      sf = 1'b0;
    end
  endtask

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic longint so(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  int     lanes [0:4];
  int     rstart, idx;
  longint offv, s;

  initial begin
    reset = 1'b1; dis = 1'b0; rstep = '0; dyn = 1'b0;
    offset = 16'd10; seq = 16'd5;
    set4(100, 200, 300, 400);
    w1 = '0; v1 = 1'b1; w5 = '0; v5 = '1;

    // Reset state, then OFF->RAMP_UP->ON and first-sample latency
    run(2);
    chk("rst_out", so(o4), 0);
    chk("rst_valid", sv4, 0);
    chk("rst_sat", sat4, 0);
    chk("rst_active", act4, 0);
    chk("rst_busy", busy4, 0);
    reset = 1'b0;
    tick();
    chk("up_busy", busy4, 1);
    chk("up_active", act4, 0);
    tick();
    chk("on_active", act4, 1);
    chk("on_busy", busy4, 0);
    run(3);
    chk("lat_valid_early", sv4, 0);
    tick();
    chk("lat_out", so(o4), 1015);
    chk("lat_valid", sv4, 1);

    // Saturation, including an offset term that would wrap in DATA_W bits
    set4(16000, 16000, 16000, 16000); run(6);
    chk("sat_pos_out", so(o4), 32767);
    chk("sat_pos_flag", sat4, 1);
    set4(-16000, -16000, -16000, -16000); run(6);
    chk("sat_neg_out", so(o4), -32768);
    chk("sat_neg_flag", sat4, 1);
    offset = 16'h8000; seq = 16'hffff; set4(0, 0, 0, 0); run(6);
    chk("off_nowrap_out", so(o4), -32768);
    chk("off_nowrap_flag", sat4, 1);
    offset = 16'd10; seq = 16'd5; set4(100, 200, 300, 400); run(6);
    chk("nosat_out", so(o4), 1015);
    chk("nosat_flag", sat4, 0);

    // Offset gate and its latency
    dyn = 1'b1; run(6);
    chk("dyn_dis_out", so(o4), 1000);
    dyn = 1'b0; run(5);
    chk("dyn_before_L", so(o4), 1000);
    tick();
    chk("dyn_at_L", so(o4), 1015);

    // Ramp down from ON with step 8192
    dyn = 1'b1; run(6);
    rstep = 16'd8192; dis = 1'b1;
    tick();
    chk("dn_busy", busy4, 1);
    chk("dn_active", act4, 0);
    tick();
    chk("dn_out0", so(o4), 1000);
    tick();
    chk("dn_out1", so(o4), 750);
    tick();
    chk("dn_out2", so(o4), 500);
    chk("dn_off_active", act4, 0);
    chk("dn_off_busy", busy4, 0);
    tick();
    chk("dn_out3", so(o4), 250);
    tick();
    chk("dn_out4", so(o4), 0);
    run(3);
    chk("off_out", so(o4), 0);
    chk("off_valid", sv4, 1);

    // Ramp up, then reversal at 16384
    dis = 1'b0;
    tick();
    chk("ru_busy", busy4, 1);
    run(4);
    chk("ru_active", act4, 1);
    dis = 1'b1;
    run(2);
    chk("rev_down_busy", busy4, 1);
    dis = 1'b0;
    tick();
    chk("rev_up_busy", busy4, 1);
    chk("rev_up_active", act4, 0);
    tick();
    chk("rev_on_active", act4, 1);
    chk("rev_out_mid", so(o4), 500);
    tick();
    chk("rev_out_g3", so(o4), 750);
    tick();
    chk("rev_out_full", so(o4), 1000);

    // Single-cycle valid drop
    v4 = 4'b1011;
    tick();
    v4 = 4'hf;
    run(4);
    chk("vdrop_pre", sv4, 1);
    tick();
    chk("vdrop_at_L", sv4, 0);
    tick();
    chk("vdrop_post", sv4, 1);

    // Reset in the middle of a ramp-down with data in flight
    dyn = 1'b0; set4(16000, 16000, 16000, 16000); run(6);
    rstep = 16'd8192; dis = 1'b1;
    run(2);
    chk("mid_busy", busy4, 1);
    reset = 1'b1;
    tick();
    chk("mrst_out", so(o4), 0);
    chk("mrst_valid", sv4, 0);
    chk("mrst_sat", sat4, 0);
    chk("mrst_active", act4, 0);
    chk("mrst_busy", busy4, 0);
    reset = 1'b0;
    tick();
    chk("mrst_stay_off", busy4, 0);
    run(6);
    chk("mrst_drain_out", so(o4), 0);
    chk("mrst_drain_valid", sv4, 1);

    // Randomized phase at unity gain on all three builds
    dis = 1'b0; rstep = '0;
    run(2);
    chk("rnd_on4", act4, 1);
    chk("rnd_on1", act1, 1);
    chk("rnd_on5", act5, 1);
    chk("rnd_busy1", busy1, 0);
    chk("rnd_busy5", busy5, 0);
    rstart = cyc;
    for (int k = 0; k < 308; k++) begin
      if (k < 300) begin
        dyn = 1'($urandom_range(0, 1));
        offset = 16'(rnd16());
        seq = 16'(rnd16());
        for (int i = 0; i < 5; i++)
          lanes[i] = ($urandom_range(0, 3) == 0) ? rnd16() : int'($urandom_range(0, 4000)) - 2000;
        v5 = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'h1f;
        for (int i = 0; i < 5; i++) w5[i*16 +: 16] = 16'(lanes[i]);
        for (int i = 0; i < 4; i++) w4[i*16 +: 16] = 16'(lanes[i]);
        w1 = 16'(lanes[0]);
        v4 = v5[3:0];
        v1 = v5[0];
      end
      offv = dyn ? 0 : so(offset) + so(seq);
      s = offv + lanes[0];
      model(s, 32768, eo1[cyc], es1[cyc]);
      s = s + lanes[1] + lanes[2] + lanes[3];
      model(s, 32768, eo4[cyc], es4[cyc]);
      s = s + lanes[4];
      model(s, 32768, eo5[cyc], es5[cyc]);
      ev1[cyc] = v5[0];
      ev4[cyc] = &v5[3:0];
      ev5[cyc] = &v5;
      tick();
      idx = cyc - 4;
      if (idx >= rstart) begin
        chk($sformatf("rnd1_out@%0d", idx), so(o1), eo1[idx]);
        chk($sformatf("rnd1_sat@%0d", idx), sat1, es1[idx]);
        chk($sformatf("rnd1_vld@%0d", idx), sv1, ev1[idx]);
      end
      idx = cyc - 6;
      if (idx >= rstart) begin
        chk($sformatf("rnd4_out@%0d", idx), so(o4), eo4[idx]);
        chk($sformatf("rnd4_sat@%0d", idx), sat4, es4[idx]);
        chk($sformatf("rnd4_vld@%0d", idx), sv4, ev4[idx]);
      end
      idx = cyc - 7;
      if (idx >= rstart) begin
        chk($sformatf("rnd5_out@%0d", idx), so(o5), eo5[idx]);
        chk($sformatf("rnd5_sat@%0d", idx), sat5, es5[idx]);
        chk($sformatf("rnd5_vld@%0d", idx), sv5, ev5[idx]);
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
